// File: rtl/dot_update_writer_if.sv
// Bus bundle between the CPU dot port, the writer and the VGA dot-position registers.
// slave = writer view, master = CPU/VGA-side view.
interface dot_update_writer_if;
  logic        screenEnd;
  logic        req_valid;
  logic [31:0] req_id;
  logic [9:0]  req_x;
  logic [8:0]  req_y;
  logic        req_ready;
  logic        id_err;
  logic        dotWren;
  logic        is_Yloc;
  logic [31:0] dotID;
  logic [31:0] dotLoc;
  logic        busy;
  logic        frame_ack;

  modport slave (
    input  screenEnd, req_valid, req_id, req_x, req_y,
    output req_ready, id_err, dotWren, is_Yloc, dotID, dotLoc, busy, frame_ack
  );

  modport master (
    output screenEnd, req_valid, req_id, req_x, req_y,
    input  req_ready, id_err, dotWren, is_Yloc, dotID, dotLoc, busy, frame_ack
  );
endinterface

// File: rtl/dot_update_writer.sv
// Buffers CPU dot-position requests and replays each as strobed X then Y writes after a frame edge.
// Optional macro DOT_CLAMP_EN saturates coordinates to 639/479 at push time.
module dot_update_writer #(
  parameter int NUM_DOTS   = 20,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               reset,
  dot_update_writer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, SET_X, STROBE_X, HOLD_X, SET_Y, STROBE_Y, HOLD_Y
  } state_t;

  logic [31:0] mem_id [FIFO_DEPTH];
  logic [9:0]  mem_x  [FIFO_DEPTH];
  logic [8:0]  mem_y  [FIFO_DEPTH];

  state_t      state_q;
  logic [AW:0] wr_q, rd_q, count;
  logic [AW:0] rd_inc;
  logic [AW-1:0] wr_idx, rd_idx, rd_nxt_idx;
  logic        se_q;
  logic        full, empty, id_ok, push, reject, frame_edge, more_d;
  logic [9:0]  push_x;
  logic [8:0]  push_y;
  logic [31:0] ld_id_d;
  logic [9:0]  ld_x_d;
  logic [8:0]  ld_y_d;
  logic [31:0] dot_id_q, dot_loc_q;
  logic [8:0]  cur_y_q;
  logic        is_y_q, wren_q, busy_q, ack_q, id_err_q;

`ifdef DOT_CLAMP_EN
  function automatic logic [9:0] sat_x(input logic [9:0] v);
    return (v > 10'd639) ? 10'd639 : v;
  endfunction

  function automatic logic [8:0] sat_y(input logic [8:0] v);
    return (v > 9'd479) ? 9'd479 : v;
  endfunction

  assign push_x = sat_x(bus.req_x);
  assign push_y = sat_y(bus.req_y);
`else
  assign push_x = bus.req_x;
  assign push_y = bus.req_y;
`endif

  assign count      = wr_q - rd_q;
  assign rd_inc     = rd_q + PTR_ONE;
  assign wr_idx     = wr_q[AW-1:0];
  assign rd_idx     = rd_q[AW-1:0];
  assign rd_nxt_idx = rd_inc[AW-1:0];
  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_idx == rd_idx);
  assign id_ok      = (bus.req_id < 32'(NUM_DOTS));
  assign push       = bus.req_valid && !full && id_ok;
  assign reject     = bus.req_valid && !full && !id_ok;
  assign frame_edge = bus.screenEnd && !se_q;

  // In HOLD_Y the next head is either the entry behind the one being popped,
  // or, when that was the last one, a request being pushed in this very cycle.
  assign more_d = (count > PTR_ONE) || push;

  always_comb begin
    ld_id_d = mem_id[rd_idx];
    ld_x_d  = mem_x[rd_idx];
    ld_y_d  = mem_y[rd_idx];
    if (state_q == HOLD_Y) begin
      if (count > PTR_ONE) begin
        ld_id_d = mem_id[rd_nxt_idx];
        ld_x_d  = mem_x[rd_nxt_idx];
        ld_y_d  = mem_y[rd_nxt_idx];
      end else begin
        ld_id_d = bus.req_id;
        ld_x_d  = push_x;
        ld_y_d  = push_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_idx] <= bus.req_id;
      mem_x[wr_idx]  <= push_x;
      mem_y[wr_idx]  <= push_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      se_q      <= 1'b1;
      dot_id_q  <= '0;
      dot_loc_q <= '0;
      cur_y_q   <= '0;
      is_y_q    <= 1'b0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      id_err_q  <= 1'b0;
    end else begin
      se_q     <= bus.screenEnd;
      id_err_q <= reject;
      ack_q    <= 1'b0;
      if (push) wr_q <= wr_q + PTR_ONE;
      case (state_q)
        IDLE: begin
          if (frame_edge && !empty) begin
            state_q   <= SET_X;
            busy_q    <= 1'b1;
            dot_id_q  <= ld_id_d;
            dot_loc_q <= {22'd0, ld_x_d};
            cur_y_q   <= ld_y_d;
            is_y_q    <= 1'b0;
          end
        end
        SET_X: begin
          state_q <= STROBE_X;
          wren_q  <= 1'b1;
        end
        STROBE_X: begin
          state_q <= HOLD_X;
          wren_q  <= 1'b0;
        end
        HOLD_X: begin
          state_q   <= SET_Y;
          dot_loc_q <= {23'd0, cur_y_q};
          is_y_q    <= 1'b1;
        end
        SET_Y: begin
          state_q <= STROBE_Y;
          wren_q  <= 1'b1;
        end
        STROBE_Y: begin
          state_q <= HOLD_Y;
          wren_q  <= 1'b0;
        end
        HOLD_Y: begin
          rd_q <= rd_inc;
          if (more_d) begin
            state_q   <= SET_X;
            dot_id_q  <= ld_id_d;
            dot_loc_q <= {22'd0, ld_x_d};
            cur_y_q   <= ld_y_d;
            is_y_q    <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wren_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = !full;
  assign bus.id_err    = id_err_q;
  assign bus.dotWren   = wren_q;
  assign bus.is_Yloc   = is_y_q;
  assign bus.dotID     = dot_id_q;
  assign bus.dotLoc    = dot_loc_q;
  assign bus.busy      = busy_q;
  assign bus.frame_ack = ack_q;
endmodule

// File: tb/tb_dot_update_writer.sv
// Directed bench for dot_update_writer: vector table of single-dot drains plus multi-cycle sequences.
module tb_dot_update_writer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dot_update_writer_if bus();
  dot_update_writer #(.NUM_DOTS(20), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] id;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        ok;
    logic [31:0] ex;
    logic [31:0] ey;
  } vec_t;

  vec_t        vecs [7];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          ack_cyc;
  int          n_str;
  int          s_cyc [32];
  logic [31:0] s_id  [32];
  logic [31:0] s_loc [32];
  logic        s_y   [32];
  int          bad;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] id, input logic [9:0] x, input logic [8:0] y);
    bus.req_valid = 1'b1;
    bus.req_id = id;
    bus.req_x = x;
    bus.req_y = y;
    step();
    bus.req_valid = 1'b0;
  endtask

  // Raises screenEnd at cycle E and observes cycles E+1..E+maxc; optionally
  // injects one push during cycle E+inj_cyc.
  task automatic drain_watch(input int maxc, input int inj_cyc, input logic [31:0] iid,
                             input logic [9:0] ix, input logic [8:0] iy);
    ack_cyc = -1;
    n_str = 0;
    bus.screenEnd = 1'b1;
    for (int c = 1; c <= maxc && ack_cyc < 0; c++) begin
      step();
      if (c == 3) bus.screenEnd = 1'b0;
      if (c == inj_cyc) begin
        bus.req_valid = 1'b1;
        bus.req_id = iid;
        bus.req_x = ix;
        bus.req_y = iy;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (bus.dotWren && n_str < 32) begin
        s_cyc[n_str] = c;
        s_id[n_str]  = bus.dotID;
        s_loc[n_str] = bus.dotLoc;
        s_y[n_str]   = bus.is_Yloc;
        n_str++;
      end
      if (bus.frame_ack) ack_cyc = c;
    end
    bus.req_valid = 1'b0;
    bus.screenEnd = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{id: 32'd3,  x: 10'd100,  y: 9'd200, ok: 1'b1, ex: 32'd100, ey: 32'd200};
    vecs[1] = '{id: 32'd19, x: 10'd0,    y: 9'd0,   ok: 1'b1, ex: 32'd0,   ey: 32'd0};
    vecs[2] = '{id: 32'd7,  x: 10'd639,  y: 9'd479, ok: 1'b1, ex: 32'd639, ey: 32'd479};
`ifdef DOT_CLAMP_EN
    vecs[3] = '{id: 32'd5,  x: 10'd1000, y: 9'd500, ok: 1'b1, ex: 32'd639, ey: 32'd479};
    vecs[4] = '{id: 32'd0,  x: 10'd1023, y: 9'd511, ok: 1'b1, ex: 32'd639, ey: 32'd479};
`else
    vecs[3] = '{id: 32'd5,  x: 10'd1000, y: 9'd500, ok: 1'b1, ex: 32'd1000, ey: 32'd500};
    vecs[4] = '{id: 32'd0,  x: 10'd1023, y: 9'd511, ok: 1'b1, ex: 32'd1023, ey: 32'd511};
`endif
    vecs[5] = '{id: 32'd20,          x: 10'd1, y: 9'd2, ok: 1'b0, ex: 32'd0, ey: 32'd0};
    vecs[6] = '{id: 32'hFFFF_FFFF,   x: 10'd3, y: 9'd4, ok: 1'b0, ex: 32'd0, ey: 32'd0};

    reset = 1'b1;
    bus.screenEnd = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_id = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    step();
    step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_dotWren", 32'(bus.dotWren), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.frame_ack), 32'd0);
    chk("rst_id_err", 32'(bus.id_err), 32'd0);
    chk("rst_dotID", bus.dotID, 32'd0);
    chk("rst_dotLoc", bus.dotLoc, 32'd0);
    chk("rst_is_Yloc", 32'(bus.is_Yloc), 32'd0);
    reset = 1'b0;
    step();

    // Frame edge with nothing queued
    drain_watch(12, 0, '0, '0, '0);
    chk("empty_strobes", 32'(n_str), 32'd0);
    chk("empty_ack", 32'(ack_cyc), 32'hFFFF_FFFF);
    chk("empty_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      push(vecs[i].id, vecs[i].x, vecs[i].y);
      chk($sformatf("v%0d_id_err", i), 32'(bus.id_err), 32'(!vecs[i].ok));
      step();
      chk($sformatf("v%0d_id_err_clr", i), 32'(bus.id_err), 32'd0);
      drain_watch(12, 0, '0, '0, '0);
      if (vecs[i].ok) begin
        chk($sformatf("v%0d_nstr", i), 32'(n_str), 32'd2);
        chk($sformatf("v%0d_x_cyc", i), 32'(s_cyc[0]), 32'd2);
        chk($sformatf("v%0d_x_id", i), s_id[0], vecs[i].id);
        chk($sformatf("v%0d_x_loc", i), s_loc[0], vecs[i].ex);
        chk($sformatf("v%0d_x_isY", i), 32'(s_y[0]), 32'd0);
        chk($sformatf("v%0d_y_cyc", i), 32'(s_cyc[1]), 32'd5);
        chk($sformatf("v%0d_y_id", i), s_id[1], vecs[i].id);
        chk($sformatf("v%0d_y_loc", i), s_loc[1], vecs[i].ey);
        chk($sformatf("v%0d_y_isY", i), 32'(s_y[1]), 32'd1);
        chk($sformatf("v%0d_ack_cyc", i), 32'(ack_cyc), 32'd7);
        chk($sformatf("v%0d_busy_at_ack", i), 32'(bus.busy), 32'd0);
      end else begin
        chk($sformatf("v%0d_nstr", i), 32'(n_str), 32'd0);
        chk($sformatf("v%0d_ack", i), 32'(ack_cyc), 32'hFFFF_FFFF);
      end
      step();
      chk($sformatf("v%0d_ack_clr", i), 32'(bus.frame_ack), 32'd0);
    end

    // Fill the FIFO, try a ninth request, then drain all eight
    for (int i = 0; i < 8; i++) begin
      push(32'(i), 10'(10 * i + 5), 9'(i + 1));
      if (i == 6) chk("full_ready_7", 32'(bus.req_ready), 32'd1);
    end
    chk("full_ready_8", 32'(bus.req_ready), 32'd0);
    push(32'd9, 10'd99, 9'd99);
    chk("full_drop_id_err", 32'(bus.id_err), 32'd0);
    drain_watch(60, 0, '0, '0, '0);
    chk("full_nstr", 32'(n_str), 32'd16);
    chk("full_ack_cyc", 32'(ack_cyc), 32'd49);
    bad = 0;
    for (int j = 0; j < 16 && j < n_str; j++) begin
      if (s_id[j] !== 32'(j / 2) || s_y[j] !== 1'(j % 2) ||
          s_cyc[j] != 2 + 6 * (j / 2) + 3 * (j % 2) ||
          s_loc[j] !== ((j % 2) ? 32'(j / 2 + 1) : 32'(10 * (j / 2) + 5))) begin
        bad++;
        $display("FAIL full_strobe_%0d: got id=%0d loc=%0d isY=%0d cyc=%0d", j, s_id[j], s_loc[j], s_y[j], s_cyc[j]);
      end
    end
    chk("full_strobe_errors", 32'(bad), 32'd0);
    step();
    chk("full_ready_after", 32'(bus.req_ready), 32'd1);

    // Push arriving in HOLD_Y of the last queued dot joins the same drain
    push(32'd4, 10'd11, 9'd22);
    drain_watch(30, 6, 32'd12, 10'd33, 9'd44);
    chk("late_nstr", 32'(n_str), 32'd4);
    chk("late_id", s_id[2], 32'd12);
    chk("late_x", s_loc[2], 32'd33);
    chk("late_x_cyc", 32'(s_cyc[2]), 32'd8);
    chk("late_y", s_loc[3], 32'd44);
    chk("late_ack_cyc", 32'(ack_cyc), 32'd13);
    step();

    // Reset during the X hold of a two-dot drain, screenEnd held through release
    push(32'd1, 10'd50, 9'd60);
    push(32'd2, 10'd70, 9'd80);
    bus.screenEnd = 1'b1;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("rmid_wren", 32'(bus.dotWren), 32'd0);
    chk("rmid_busy", 32'(bus.busy), 32'd0);
    chk("rmid_ready", 32'(bus.req_ready), 32'd1);
    chk("rmid_ack", 32'(bus.frame_ack), 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.dotWren || bus.frame_ack || bus.busy) bad++;
    end
    chk("rmid_quiet", 32'(bad), 32'd0);
    bus.screenEnd = 1'b0;
    step();
    drain_watch(12, 0, '0, '0, '0);
    chk("rmid_flushed_nstr", 32'(n_str), 32'd0);
    chk("rmid_flushed_ack", 32'(ack_cyc), 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_update_writer.md
# dot_update_writer

Processor-side writer for the VGA dot-position update interface. It buffers dot position requests (id, x, y) from the CPU and replays each as two strobed register writes (X, then Y) on the `dotWren`/`is_Yloc`/`dotID`/`dotLoc` bus. Draining happens only after a frame boundary (`screenEnd`), so positions change between frames. It sits between the processor's memory-mapped dot port and the VGA controller.

## Interface

Parameters:
- `NUM_DOTS`, 20: number of valid dot IDs; accepted IDs are 0..NUM_DOTS-1.
- `FIFO_DEPTH`, 8: request buffer entries; must be a power of 2.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `screenEnd`  in  1  frame-boundary level from the timing generator, already in the `clk` domain; held high for several `clk` cycles.
- `req_valid`  in  1  CPU request strobe.
- `req_id`  in  32  dot ID.
- `req_x`  in  10  X coordinate.
- `req_y`  in  9  Y coordinate.
- `req_ready`  out  1  high when the FIFO is not full.
- `id_err`  out  1  one-cycle pulse when a request with an out-of-range ID is rejected.
- `dotWren`  out  1  write strobe to the VGA controller. The VGA side is rising-edge sensitive.
- `is_Yloc`  out  1  0 = X write, 1 = Y write.
- `dotID`  out  32  dot ID, zero-extended.
- `dotLoc`  out  32  coordinate, zero-extended.
- `busy`  out  1  high in every non-IDLE state.
- `frame_ack`  out  1  one-cycle pulse when a drain completes.

## Operation

- **Push:**
  - A push occurs when `req_valid && req_ready && req_id < NUM_DOTS`. It stores {id[31:0], x, y}.
  - `req_ready` is `~full`, computed combinationally. When full, requests are ignored even if a pop happens in the same cycle.
  - If `req_valid && req_ready && req_id >= NUM_DOTS`: nothing is stored, and `id_err` goes high for the next cycle.
- **Edge detect:**
  - `se_q` registers `screenEnd`. A frame edge is `screenEnd && ~se_q`.
  - `se_q` resets to 1, so a `screenEnd` that is still high when reset is released does not trigger a drain.
- **FSM states:** IDLE, SET_X, STROBE_X, HOLD_X, SET_Y, STROBE_Y, HOLD_Y.
  - IDLE → SET_X on a frame edge with the FIFO non-empty. A frame edge with the FIFO empty is ignored and produces no ack.
  - SET_X: `dotID` = head id, `dotLoc` = x, `is_Yloc` = 0, `dotWren` = 0.
  - STROBE_X: same data, `dotWren` = 1.
  - HOLD_X: same data, `dotWren` = 0.
  - SET_Y, STROBE_Y, HOLD_Y: same pattern with `dotLoc` = y and `is_Yloc` = 1.
  - HOLD_Y pops the head. Next state is SET_X if the FIFO holds another entry, otherwise IDLE with a `frame_ack` pulse.
- Entries pushed during a drain are included in the same drain. Frame edges during a drain are ignored.
- Data fields are stable from SET through HOLD, so they are valid one cycle before and one cycle after the `dotWren` rising edge.
- **Reset values:** all outputs are 0 except `req_ready` = 1. FIFO pointers are 0, the FSM is in IDLE, and `se_q` = 1.
- **Reset mid-drain:** in the next cycle `dotWren` = 0 and `busy` = 0, the FIFO is flushed, and no `frame_ack` is issued. A partially written dot is left as-is on the VGA side.

## Timing

- E is the first cycle in which `screenEnd` is high.
- **Per-dot schedule:**
  - SET_X at E+1, `dotWren` high at E+2.
  - SET_Y at E+4, `dotWren` high at E+5.
  - HOLD_Y at E+6.
- Each dot takes exactly 6 cycles with no gaps between dots.
- For N dots, `frame_ack` is at E+6N+1.
- Push to FIFO visible: 1 cycle. `req_ready` falls in the cycle after the push that fills the FIFO.
- The FIFO is ordered first in, first out. Pointers wrap modulo `FIFO_DEPTH`, and an extra wrap bit distinguishes full from empty.

## Configuration

- **`DOT_CLAMP_EN` defined:** coordinates are saturated at push time. `req_x` > 639 is stored as 639; `req_y` > 479 is stored as 479.
- **`DOT_CLAMP_EN` undefined:** coordinates are stored and emitted unchanged.

## Test plan

- **Single dot:** after reset, push id=3, x=100, y=200, then raise `screenEnd` at E.
  - E+2: `dotWren` = 1, `dotID` = 3, `is_Yloc` = 0, `dotLoc` = 100.
  - E+5: `dotWren` = 1, `is_Yloc` = 1, `dotLoc` = 200.
  - E+7: `frame_ack` = 1, `busy` = 0.
- **Full FIFO:** push 8 requests, ids 0..7.
  - `req_ready` = 0 after the 8th; a 9th push (id 9) is dropped.
  - The drain emits 16 strobes in id order 0..7, and `frame_ack` fires at E+49.
- **Out-of-range ID:** push id=20 with `NUM_DOTS`=20, then a frame edge.
  - `id_err` pulses once.
  - No `dotWren` and no `frame_ack` follow.
- **Clamp:** push x=1000, y=500.
  - With `DOT_CLAMP_EN`: `dotLoc` values are 639 and 479.
  - Without it: 1000 and 500.
- **Reset mid-drain:** assert `reset` at E+3 of a 2-dot drain and keep `screenEnd` high through reset release.
  - Next cycle: `dotWren` = 0, `busy` = 0, `req_ready` = 1.
  - No `frame_ack` is issued and no new drain starts.
- **Frame edge on empty FIFO:** pulse `screenEnd` with the FIFO empty; `dotWren` and `frame_ack` stay 0.
